// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package hilo_pkg;

  // Op field encodings as presented by the ID/EX stage; 11x is not an operation.
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIX   = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  // Iteration counter width for a given operand width.
  function automatic int iter_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int WIDTH_DEF  = 32;
  localparam int ITER_CNT_W = $clog2(WIDTH_DEF + 1);

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: shift-add multiply / restoring divide on magnitudes.
// Latency: one step per cycle, WIDTH steps per operation; last flags the final step.
// Backpressure: none; the controller alone decides when to init and step.
module muldiv_iter
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               step_mul,
  input  logic               step_div,
  input  logic [WIDTH-1:0]   init_lo,
  input  logic [WIDTH-1:0]   init_opnd,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CNT_W = iter_cnt_w(WIDTH);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd;

  // Multiply step: add multiplicand into the upper half when the low bit is set,
  // then shift the whole accumulator right, keeping the carry.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: shift left one, trial-subtract divisor from the partial remainder,
  // keep the difference and set the quotient bit when it does not go negative.
  logic [WIDTH:0]       div_part;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  assign div_part = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_part - {1'b0, opnd};
  assign div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // Accumulator, operand and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      opnd <= '0;
      cnt  <= '0;
    end else if (init) begin
      acc  <= {{WIDTH{1'b0}}, init_lo};
      opnd <= init_opnd;
      cnt  <= '0;
    end else if (step_mul) begin
      acc <= mul_next;
      cnt <= cnt + 1'b1;
    end else if (step_div) begin
      acc <= div_next;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO writes into the HI/LO register pair.
// Latency: mul/div WIDTH+2 cycles to WRITE; MTHI/MTLO and divide-by-zero 1 cycle.
// Backpressure: one op at a time; Stall holds MF* and new ops while Busy.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MfRequest,
  output logic             Busy,
  output logic             Stall,
  output logic             WriteEnable,
  output logic             mthi,
  output logic             mtlo,
  output logic [WIDTH-1:0] Hi_wdata,
  output logic [WIDTH-1:0] Lo_wdata,
  output logic             Done,
  output logic             DivByZero
);

  state_e state, next_state;

  // Request decode: 11x is not an op, so it is never accepted.
  logic accept, op_valid, op_signed, op_is_mul, b_zero, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign op_valid  = !(Op[2] && Op[1]);
  assign accept    = (state == ST_IDLE) && Start && op_valid;
  assign op_signed = !Op[2] && !Op[0];
  assign op_is_mul = (Op[2:1] == 2'b00);
  assign b_zero    = (B == '0);
  assign a_neg     = op_signed && A[WIDTH-1];
  assign b_neg     = op_signed && B[WIDTH-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;

  // Result sign flags captured at accept: quotient/product sign and remainder sign.
  logic neg_q, neg_r, is_mul;

  logic [2*WIDTH-1:0] acc;
  logic               last;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (Clk),
    .rst       (Reset),
    .init      (accept),
    .step_mul  (state == ST_MUL),
    .step_div  (state == ST_DIV),
    .init_lo   (op_is_mul ? b_mag : a_mag),
    .init_opnd (op_is_mul ? a_mag : b_mag),
    .acc       (acc),
    .last      (last)
  );

  // Sign correction applied in FIX; the magnitude of MIN/-1 wraps back to MIN.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, fix_hi, fix_lo;
  assign prod   = neg_q ? -acc : acc;
  assign quot   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign fix_hi = is_mul ? prod[2*WIDTH-1:WIDTH] : rem;
  assign fix_lo = is_mul ? prod[WIDTH-1:0] : quot;

  assign Stall = Busy && (MfRequest || Start);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (Op)
            OP_MULT, OP_MULTU: next_state = ST_MUL;
            OP_DIV, OP_DIVU:   next_state = b_zero ? ST_WRITE : ST_DIV;
            default:           next_state = ST_WRITE;
          endcase
        end
      end
      ST_MUL, ST_DIV: if (last) next_state = ST_FIX;
      ST_FIX:         next_state = ST_WRITE;
      default:        next_state = ST_IDLE;
    endcase
  end

  // Output next-values; every output except Stall is registered from these.
  logic             busy_nxt, we_nxt, mthi_nxt, mtlo_nxt, done_nxt, dbz_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  always_comb begin
    busy_nxt = (next_state != ST_IDLE);
    we_nxt   = 1'b0;
    mthi_nxt = 1'b0;
    mtlo_nxt = 1'b0;
    done_nxt = 1'b0;
    dbz_nxt  = 1'b0;
    hi_nxt   = Hi_wdata;
    lo_nxt   = Lo_wdata;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (Op)
            OP_MTHI: begin
              we_nxt   = 1'b1;
              done_nxt = 1'b1;
              mthi_nxt = 1'b1;
              hi_nxt   = A;
            end
            OP_MTLO: begin
              we_nxt   = 1'b1;
              done_nxt = 1'b1;
              mtlo_nxt = 1'b1;
              lo_nxt   = A;
            end
            OP_DIV, OP_DIVU: begin
              if (b_zero) begin
                we_nxt   = 1'b1;
                done_nxt = 1'b1;
                dbz_nxt  = 1'b1;
                hi_nxt   = A;
                lo_nxt   = '1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_FIX: begin
        we_nxt   = 1'b1;
        done_nxt = 1'b1;
        hi_nxt   = fix_hi;
        lo_nxt   = fix_lo;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Busy        <= 1'b0;
      WriteEnable <= 1'b0;
      mthi        <= 1'b0;
      mtlo        <= 1'b0;
      Done        <= 1'b0;
      DivByZero   <= 1'b0;
      Hi_wdata    <= '0;
      Lo_wdata    <= '0;
    end else begin
      Busy        <= busy_nxt;
      WriteEnable <= we_nxt;
      mthi        <= mthi_nxt;
      mtlo        <= mtlo_nxt;
      Done        <= done_nxt;
      DivByZero   <= dbz_nxt;
      Hi_wdata    <= hi_nxt;
      Lo_wdata    <= lo_nxt;
    end
  end

  // Sign flags latched on the accept edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_mul <= 1'b0;
    end else if (accept) begin
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      is_mul <= op_is_mul;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl (WIDTH=32).
// Latency: checks exact cycle of WRITE for each op class.
// Backpressure: checks Stall for MF* requests and held Start.
module tb_hilo_muldiv_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, Start, MfRequest;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Stall, WriteEnable, mthi, mtlo, Done, DivByZero;
  logic [31:0] Hi_wdata, Lo_wdata;

  int total = 0;
  int bad   = 0;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Op          (Op),
    .A           (A),
    .B           (B),
    .MfRequest   (MfRequest),
    .Busy        (Busy),
    .Stall       (Stall),
    .WriteEnable (WriteEnable),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .Hi_wdata    (Hi_wdata),
    .Lo_wdata    (Lo_wdata),
    .Done        (Done),
    .DivByZero   (DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at edge 0, then check Busy span, single WRITE at cycle lat, and
  // return to idle at cycle lat+1.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz,
                        input logic exp_mthi, input logic exp_mtlo);
    int busy_low = 0;
    int early_we = 0;
    Op = op; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      if (!Busy) busy_low++;
      if (c < lat) begin
        if (WriteEnable || Done) early_we++;
      end else begin
        chk({tag, " we"},   {31'd0, WriteEnable}, 32'd1);
        chk({tag, " done"}, {31'd0, Done}, 32'd1);
        chk({tag, " dbz"},  {31'd0, DivByZero}, {31'd0, exp_dbz});
        chk({tag, " mthi"}, {31'd0, mthi}, {31'd0, exp_mthi});
        chk({tag, " mtlo"}, {31'd0, mtlo}, {31'd0, exp_mtlo});
        chk({tag, " hi"},   Hi_wdata, exp_hi);
        chk({tag, " lo"},   Lo_wdata, exp_lo);
      end
      tick();
    end
    chk({tag, " busy_span"}, busy_low, 32'd0);
    chk({tag, " early_we"},  early_we, 32'd0);
    chk({tag, " busy_end"},  {31'd0, Busy}, 32'd0);
    chk({tag, " we_end"},    {31'd0, WriteEnable}, 32'd0);
  endtask

  initial begin
    int cnt;
    Reset = 1'b1; Start = 1'b0; MfRequest = 1'b0; Op = 3'b000; A = '0; B = '0;
    tick();
    tick();
    Reset = 1'b0;

    // Reset state
    chk("rst busy", {31'd0, Busy}, 32'd0);
    chk("rst we",   {31'd0, WriteEnable}, 32'd0);
    chk("rst done", {31'd0, Done}, 32'd0);
    chk("rst hi",   Hi_wdata, 32'd0);
    chk("rst lo",   Lo_wdata, 32'd0);

    // Multiplies: -2*3 signed, max*max unsigned, 7*-3 signed
    run_op("mult",  3'b000, 32'hFFFFFFFE, 32'd3, 34, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0, 1'b0);
    run_op("multu", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b0);
    run_op("mult2", 3'b000, 32'd7, 32'hFFFFFFFD, 34, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0);

    // Divides: -7/2, 100/7 unsigned, MIN/-1, 7/-2
    run_op("div",   3'b010, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
    run_op("divu",  3'b011, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0);
    run_op("divmin",3'b010, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000, 1'b0, 1'b0, 1'b0);
    run_op("div2",  3'b010, 32'd7, 32'hFFFFFFFE, 34, 32'd1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);

    // Divide by zero: one-cycle write
    run_op("divz",  3'b011, 32'h1234, 32'd0, 1, 32'h1234, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);

    // MTHI: Lo holds previous value
    run_op("mthi",  3'b100, 32'hBEEF, 32'd0, 1, 32'hBEEF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);

    // MTLO with MfRequest held from cycle 1
    Op = 3'b101; A = 32'hCAFE; Start = 1'b1;
    tick();
    Start = 1'b0; MfRequest = 1'b1;
    chk("mtlo mtlo",  {31'd0, mtlo}, 32'd1);
    chk("mtlo mthi",  {31'd0, mthi}, 32'd0);
    chk("mtlo lo",    Lo_wdata, 32'hCAFE);
    chk("mtlo hi",    Hi_wdata, 32'hBEEF);
    chk("mtlo stall", {31'd0, Stall}, 32'd1);
    tick();
    chk("mtlo stall2", {31'd0, Stall}, 32'd0);
    chk("mtlo busy2",  {31'd0, Busy}, 32'd0);
    MfRequest = 1'b0;

    // Invalid op 11x ignored
    Op = 3'b110; A = 32'h5; B = 32'h5; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("inv busy", {31'd0, Busy}, 32'd0);
    tick();
    chk("inv we",   {31'd0, WriteEnable}, 32'd0);

    // Held Start during MULT 5*6: stalled until IDLE, then MTHI accepted
    Op = 3'b000; A = 32'd5; B = 32'd6; Start = 1'b1;
    tick();
    Op = 3'b100; A = 32'h77; B = 32'd0;
    cnt = 0;
    for (int c = 1; c <= 34; c++) begin
      if (!Stall) cnt++;
      if (c < 34) tick();
    end
    chk("b2b stall_span", cnt, 32'd0);
    chk("b2b we",   {31'd0, WriteEnable}, 32'd1);
    chk("b2b lo",   Lo_wdata, 32'd30);
    chk("b2b hi",   Hi_wdata, 32'd0);
    tick();
    chk("b2b idle_busy",  {31'd0, Busy}, 32'd0);
    chk("b2b idle_stall", {31'd0, Stall}, 32'd0);
    tick();
    Start = 1'b0;
    chk("b2b mthi",  {31'd0, mthi}, 32'd1);
    chk("b2b hi2",   Hi_wdata, 32'h77);
    chk("b2b lo2",   Lo_wdata, 32'd30);
    tick();
    chk("b2b busy3", {31'd0, Busy}, 32'd0);

    // Reset mid-MULT at cycle 10
    Op = 3'b000; A = 32'hFFFFFFFE; B = 32'd3; Start = 1'b1;
    tick();
    Start = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      if (WriteEnable) cnt++;
      if (c == 10) Reset = 1'b1;
      tick();
    end
    Reset = 1'b0;
    chk("rmid we_cnt", cnt, 32'd0);
    chk("rmid busy",  {31'd0, Busy}, 32'd0);
    chk("rmid we",    {31'd0, WriteEnable}, 32'd0);
    chk("rmid flags", {26'd0, mthi, mtlo, Done, DivByZero, Stall, 1'b0}, 32'd0);
    chk("rmid hi",    Hi_wdata, 32'd0);
    chk("rmid lo",    Lo_wdata, 32'd0);
    run_op("rmid divu", 3'b011, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Iterative multiply/divide controller that sequences all writes into the HI/LO register pair (HiLo_reg) for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Accepts one operation at a time from the ID/EX stage.
- Runs a shift-add multiply or restoring divide for WIDTH cycles.
- Drives HiLo_reg's WriteEnable, mthi, mtlo, Hi and Lo inputs.
- Generates the pipeline stall for MFHI/MFLO and back-to-back HI/LO ops while busy.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  operation request, sampled each Clk edge.
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x ignored.
- A  input  WIDTH  rs operand (dividend / multiplicand / mthi/mtlo source).
- B  input  WIDTH  rt operand (divisor / multiplier).
- MfRequest  input  1  MFHI/MFLO currently in ID.
- Busy  output  1  operation accepted and HI/LO write not yet done.
- Stall  output  1  combinational: Busy & (MfRequest | Start).
- WriteEnable  output  1  to HiLo_reg WriteEnable.
- mthi  output  1  to HiLo_reg mthi.
- mtlo  output  1  to HiLo_reg mtlo.
- Hi_wdata  output  WIDTH  to HiLo_reg Hi.
- Lo_wdata  output  WIDTH  to HiLo_reg Lo.
- Done  output  1  one-cycle pulse, same cycle as WriteEnable.
- DivByZero  output  1  one-cycle pulse with Done when DIV/DIVU has B==0.

Behaviour:
- Reset: all outputs 0, state IDLE, internal accumulators cleared. Reset mid-operation aborts with no HI/LO write.
- States: IDLE, MUL, DIV, FIX, WRITE. All outputs except Stall are registered.
- Start is accepted only in IDLE with a valid Op; otherwise ignored. The requester holds Start while Stall=1.
- A and B are latched on the accept edge (edge 0). Signed ops latch magnitudes plus result-sign flags.
- MUL / DIV:
  - Edge 0 enters MUL or DIV.
  - Cycles 1..WIDTH: one iteration each.
  - Cycle WIDTH+1: FIX (sign correction).
  - Cycle WIDTH+2: WRITE, with WriteEnable=1, mthi=0, mtlo=0, Done=1.
  - Busy=1 from cycle 1 through WRITE inclusive; returns to IDLE the next edge.
- MULT/MULTU: 2*WIDTH-bit product; Hi_wdata=product[2W-1:W], Lo_wdata=product[W-1:0]. Signed: negate magnitude product if operand signs differ.
- DIV/DIVU:
  - Lo=quotient, Hi=remainder.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives Lo=0x80000000, Hi=0.
- Divide by zero: skip DIV/FIX and go straight to WRITE at cycle 1. Hi=A, Lo=all-ones, DivByZero=1; Busy is high for that cycle only.
- MTHI / MTLO: WRITE at cycle 1.
  - MTHI: mthi=1, Hi_wdata=A.
  - MTLO: mtlo=1, Lo_wdata=A.
  - The unused data output holds its prior value.
- Outside WRITE: WriteEnable, mthi, mtlo, Done and DivByZero are 0; Hi_wdata/Lo_wdata hold their last values.
- Hazard timing: HiLo_reg updates on the WRITE edge, so MfRequest stalls through WRITE and is released in the following IDLE cycle. Start presented during WRITE is stalled and accepted in IDLE.

Decomposition:
- Package hilo_pkg:
  - Op encodings (OP_MULT..OP_MTLO).
  - State enum.
  - ITER_CNT_W = $clog2(WIDTH+1).
- One sub-module, muldiv_iter:
  - Holds the 2*WIDTH-bit accumulator, shift-add/restoring-subtract step and iteration counter.
  - Controlled by init, step_mul, step_div.
- The controller FSM, sign handling and output registers stay in hilo_muldiv_ctrl.

Test Plan:
1. MULT, A=0xFFFFFFFE, B=3, Start at edge 0 → cycles 1..34 Busy=1; cycle 34 WriteEnable=Done=1, Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; cycle 35 Busy=0.
2. MULTU, A=B=0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001 in cycle 34; mthi=mtlo=0.
3. DIV, A=0xFFFFFFF9 (-7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU A=100, B=7 → Lo=14, Hi=2.
4. DIVU, A=0x1234, B=0 → cycle 1 WriteEnable=Done=DivByZero=1, Hi=0x1234, Lo=0xFFFFFFFF; Busy high only in cycle 1.
5. MTLO, A=0xCAFE, then MfRequest held from cycle 1 → cycle 1 mtlo=1, Lo_wdata=0xCAFE, Stall=1; cycle 2 Stall=0. A second Start during MULT stays stalled until IDLE, then is accepted.
6. MULT started, Reset asserted at cycle 10 → cycle 11 all outputs 0, no WriteEnable ever pulses; a new Start in cycle 11 is accepted normally.
